// File: rtl/cpu_clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl_pkg
// Brief    : Shared state encoding and defaults for the CPU run/stop control.
// Revision : 1.0
// ============================================================================
package cpu_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        STEP    = 2'd2,
        HALTED  = 2'd3
    } cc_state_t;

    // 20 ms of stable level at 12 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Synchronizes and debounces an active-low pushbutton; emits a
//            one-cycle pulse when the debounced level falls.
// Revision : 1.0
// ============================================================================
module btn_debounce
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == C_TERMINAL) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    // only the press (falling) edge is reported
                    r_press  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Brief    : Run/stop/single-step controller turning divided tick edges into
//            gated one-cycle CPU clock enables.
// Revision : 1.0
// ============================================================================
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             tick_in,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    logic             r_tick_s1;
    logic             r_tick_s2;
    logic             r_tick_prev;
    logic             w_tick;
    logic             w_run_press;
    logic             w_step_press;
    cc_state_t        r_state;
    cc_state_t        w_state_next;
    logic             w_ce_next;
    logic             r_cpu_ce;
    logic             r_running;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk     (clk),
        .rst_n   (rst_btn),
        .btn_raw (run_btn),
        .press   (w_run_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .rst_n   (rst_btn),
        .btn_raw (step_btn),
        .press   (w_step_press)
    );

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_tick_s1   <= 1'b0;
            r_tick_s2   <= 1'b0;
            r_tick_prev <= 1'b0;
        end else begin
            r_tick_s1   <= tick_in;
            r_tick_s2   <= r_tick_s1;
            r_tick_prev <= r_tick_s2;
        end
    end

    assign w_tick = r_tick_s2 & ~r_tick_prev;

    // Halt is checked first so it suppresses a coincident tick or press.
    always_comb begin
        w_state_next = r_state;
        w_ce_next    = 1'b0;
        case (r_state)
            STOPPED: begin
                if (w_run_press)
                    w_state_next = RUNNING;
                else if (w_step_press)
                    w_state_next = STEP;
            end
            RUNNING: begin
                if (halt_req) begin
                    w_state_next = HALTED;
                end else begin
                    w_ce_next = w_tick;
                    if (w_run_press)
                        w_state_next = STOPPED;
                end
            end
            STEP: begin
                if (halt_req) begin
                    w_state_next = HALTED;
                end else if (w_run_press) begin
                    w_state_next = RUNNING;
                end else if (w_tick) begin
                    w_ce_next    = 1'b1;
                    w_state_next = STOPPED;
                end
            end
            HALTED: begin
                w_state_next = HALTED;
            end
            default: begin
                w_state_next = STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_state       <= STOPPED;
            r_cpu_ce      <= 1'b0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cpu_ce      <= w_ce_next;
            r_running     <= (w_state_next == RUNNING);
            r_halted      <= (w_state_next == HALTED);
            r_cycle_count <= r_cycle_count + CNT_W'(w_ce_next);
        end
    end

    assign cpu_ce      = r_cpu_ce;
    assign running     = r_running;
    assign halted      = r_halted;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clock_ctrl
// Brief    : Self-checking bench for cpu_clock_ctrl with a history-based model.
// Revision : 1.0
// ============================================================================
module tb_cpu_clock_ctrl;

    localparam int D = 4;
    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_btn  = 1'b0;
    logic         tick_in  = 1'b0;
    logic         run_btn  = 1'b1;
    logic         step_btn = 1'b1;
    logic         halt_req = 1'b0;
    logic         cpu_ce;
    logic         running;
    logic         halted;
    logic [W-1:0] cycle_count;

    int n_cmp   = 0;
    int n_bad   = 0;
    int ce_seen = 0;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (W)
    ) dut (
        .clk         (clk),
        .rst_btn     (rst_btn),
        .tick_in     (tick_in),
        .run_btn     (run_btn),
        .step_btn    (step_btn),
        .halt_req    (halt_req),
        .cpu_ce      (cpu_ce),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model: raw pin samples kept per edge; tick and debounced
    // presses derived from sample windows, mode 0..3 = stop/run/step/halt.
    bit th [0:3];
    bit rh [0:D+1];
    bit sh [0:D+1];
    bit r_stab, s_stab, m_rp, m_sp, m_ce;
    int m_mode, m_count;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) th[i] = 1'b0;
        for (int i = 0; i < D + 2; i++) begin
            rh[i] = 1'b1;
            sh[i] = 1'b1;
        end
        r_stab = 1'b1; s_stab = 1'b1;
        m_rp = 1'b0; m_sp = 1'b0; m_ce = 1'b0;
        m_mode = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit tk, flip;
        for (int i = 3; i > 0; i--) th[i] = th[i-1];
        th[0] = tick_in;
        for (int i = D + 1; i > 0; i--) begin
            rh[i] = rh[i-1];
            sh[i] = sh[i-1];
        end
        rh[0] = run_btn;
        sh[0] = step_btn;
        tk = th[2] & ~th[3];

        m_ce = 1'b0;
        case (m_mode)
            0: if (m_rp) m_mode = 1; else if (m_sp) m_mode = 2;
            1: if (halt_req) m_mode = 3;
               else begin m_ce = tk; if (m_rp) m_mode = 0; end
            2: if (halt_req) m_mode = 3;
               else if (m_rp) m_mode = 1;
               else if (tk) begin m_ce = 1'b1; m_mode = 0; end
            default: m_mode = 3;
        endcase
        if (m_ce) m_count = (m_count + 1) % (1 << W);

        // level accepted when the last D compared samples all disagree
        flip = 1'b1;
        for (int i = 2; i < D + 2; i++) if (rh[i] == r_stab) flip = 1'b0;
        m_rp = 1'b0;
        if (flip) begin r_stab = ~r_stab; m_rp = ~r_stab; end
        flip = 1'b1;
        for (int i = 2; i < D + 2; i++) if (sh[i] == s_stab) flip = 1'b0;
        m_sp = 1'b0;
        if (flip) begin s_stab = ~s_stab; m_sp = ~s_stab; end
    endtask

    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) model_reset();
        else          model_step();
    end

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (cpu_ce) ce_seen++;
        check("model", {cpu_ce, running, halted, cycle_count},
              {m_ce, (m_mode == 1), (m_mode == 3), 4'(m_count)});
    endtask

    task automatic pulse_ticks(int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1; repeat (3) cyc();
            tick_in = 1'b0; repeat (3) cyc();
        end
    endtask

    task automatic press(bit r, bit s);
        run_btn = ~r; step_btn = ~s;
        repeat (10) cyc();
        run_btn = 1'b1; step_btn = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic do_reset();
        #2 rst_btn = 1'b0;
        repeat (3) cyc();
        rst_btn = 1'b1;
        cyc();
    endtask

    typedef struct {
        bit run;
        bit step;
        bit halt;
        int ticks;
        bit exp_run;
        bit exp_halt;
        int exp_cnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        bit got;
        model_reset();
        tbl[0] = '{0, 0, 0, 5,  0, 0, 0};
        tbl[1] = '{1, 0, 0, 3,  1, 0, 3};
        tbl[2] = '{0, 0, 0, 17, 1, 0, 4};
        tbl[3] = '{1, 0, 0, 2,  0, 0, 4};
        tbl[4] = '{0, 1, 0, 2,  0, 0, 5};
        tbl[5] = '{1, 1, 0, 1,  1, 0, 6};
        tbl[6] = '{0, 0, 1, 2,  0, 1, 6};
        tbl[7] = '{1, 0, 0, 2,  0, 1, 6};

        repeat (3) cyc();
        rst_btn = 1'b1;
        cyc();
        check("rst_ce", cpu_ce, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_count", cycle_count, 0);

        for (int v = 0; v < 8; v++) begin
            if (tbl[v].run || tbl[v].step) press(tbl[v].run, tbl[v].step);
            if (tbl[v].halt) begin
                halt_req = 1'b1; cyc(); halt_req = 1'b0;
            end
            pulse_ticks(tbl[v].ticks);
            check($sformatf("vec%0d_running", v), running, tbl[v].exp_run);
            check($sformatf("vec%0d_halted", v), halted, tbl[v].exp_halt);
            check($sformatf("vec%0d_count", v), cycle_count, tbl[v].exp_cnt);
        end

        // bouncing run button must not be accepted
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_btn = ~run_btn;
            repeat (2) cyc();
        end
        repeat (8) cyc();
        check("bounce_running", running, 0);
        ce_seen = 0;
        press(0, 1);
        pulse_ticks(2);
        check("step_ce_pulses", ce_seen, 1);
        check("step_count", cycle_count, 1);
        check("step_running", running, 0);

        // three-edge latency from first high sample to cpu_ce
        press(1, 0);
        tick_in = 1'b1;
        cyc(); check("lat_k", cpu_ce, 0);
        cyc(); check("lat_k1", cpu_ce, 0);
        cyc(); check("lat_k2", cpu_ce, 1);
        cyc(); check("lat_k3", cpu_ce, 0);
        tick_in = 1'b0;
        repeat (3) cyc();

        // halt coincident with internal tick
        tick_in = 1'b1;
        cyc(); cyc();
        halt_req = 1'b1;
        cyc();
        check("halt_ce", cpu_ce, 0);
        check("halt_halted", halted, 1);
        check("halt_running", running, 0);
        halt_req = 1'b0; tick_in = 1'b0;
        repeat (3) cyc();
        press(1, 0);
        pulse_ticks(2);
        check("halt_count", cycle_count, 2);
        check("halt_stays", halted, 1);

        // reset while cpu_ce is high
        do_reset();
        press(1, 0);
        tick_in = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (cpu_ce) begin got = 1'b1; break; end
        end
        check("ce_wait", got, 1);
        #2 rst_btn = 1'b0;
        #1;
        check("midrst_ce", cpu_ce, 0);
        check("midrst_running", running, 0);
        check("midrst_count", cycle_count, 0);
        repeat (2) cyc();
        tick_in = 1'b0;
        rst_btn = 1'b1;
        cyc();
        pulse_ticks(2);
        check("post_rst_count", cycle_count, 0);

        // randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            if (i % 300 == 299) do_reset();
            if ($urandom_range(3) == 0) tick_in = ~tick_in;
            if ($urandom_range(39) == 0) run_btn = ~run_btn;
            if ($urandom_range(39) == 0) step_btn = ~step_btn;
            halt_req = ($urandom_range(249) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
